// File: rtl/swervolf_uart_pkg.sv
// Shared types and constants for the SweRVolf UART receiver.
// Optional parity support is selected by SWERVOLF_UART_RX_PARITY_EN.
package swervolf_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/swervolf_uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, extra pointer MSB separates full from empty.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module swervolf_uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: the storage is cleared on reset so the head byte reads 0 out of
      // reset; this costs a reset net per flop and rules out a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/swervolf_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, receive FIFO and sticky error flags.
// Define SWERVOLF_UART_RX_PARITY_EN for 8E1 frames with a sticky parity error flag.
module swervolf_uart_rx
  import swervolf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err,
  input  logic       i_err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  rx_state_t                 state_q, state_d;
  logic                      sync_q, rx_s;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      push_q;
  logic [UART_DATA_BITS-1:0] push_data_q;
  logic                      bit_tick;
  logic                      cnt_clr, shift_en, push_req, frame_err_set;
  logic                      fifo_full, fifo_empty;

  // Two-flop synchronizer; flops preset to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their old
      // values on the same edge; blocking here would collapse them into one.
      sync_q <= i_rx;
      rx_s   <= sync_q;
    end
  end

  assign bit_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s) state_d = ST_START;
      ST_START: if (cnt_q == CNT_MID) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (bit_tick && bit_idx_q == LAST_BIT) begin
`ifdef SWERVOLF_UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
`ifdef SWERVOLF_UART_RX_PARITY_EN
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_tick) state_d = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef SWERVOLF_UART_RX_PARITY_EN
  logic parity_set;
`endif

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    cnt_clr       = 1'b1;
    shift_en      = 1'b0;
    push_req      = 1'b0;
    frame_err_set = 1'b0;
`ifdef SWERVOLF_UART_RX_PARITY_EN
    parity_set    = 1'b0;
`endif
    case (state_q)
      ST_START: cnt_clr = (cnt_q == CNT_MID);
      ST_DATA: begin
        cnt_clr  = bit_tick;
        shift_en = bit_tick;
      end
`ifdef SWERVOLF_UART_RX_PARITY_EN
      ST_PARITY: begin
        cnt_clr    = bit_tick;
        parity_set = bit_tick && (rx_s != ^shreg_q);
      end
`endif
      ST_STOP: begin
        cnt_clr       = bit_tick;
        push_req      = bit_tick && rx_s;
        frame_err_set = bit_tick && !rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timing counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
      if (state_q == ST_IDLE) begin
        bit_idx_q <= '0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + BIT_W'(1);
        shreg_q   <= {rx_s, shreg_q[UART_DATA_BITS-1:1]};
      end
      push_q      <= push_req;
      push_data_q <= shreg_q;
    end
  end

  swervolf_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (i_ready),
    .rd_data   (o_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_valid = !fifo_empty;

  // A full FIFO with a pop in the same cycle still takes the byte.
  always_ff @(posedge clk) begin
    if (rst || i_err_clr) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (frame_err_set) o_frame_err <= 1'b1;
      if (push_q && fifo_full && !i_ready) o_overrun <= 1'b1;
    end
  end

`ifdef SWERVOLF_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || i_err_clr) o_parity_err <= 1'b0;
    else if (parity_set)  o_parity_err <= 1'b1;
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_swervolf_uart_rx.sv
// Self-checking bench: frames are scheduled into a queue model by their spec latency,
// and a negedge compare process checks every output each cycle.
module tb_swervolf_uart_rx;

  localparam int N     = 8;
  localparam int DEPTH = 4;
`ifdef SWERVOLF_UART_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam int FRAME_BITS = PARITY ? 11 : 10;
  localparam int PUSH_LAT   = 2 + N / 2 + (FRAME_BITS - 1) * N + 1;
  localparam int PAR_LAT    = 2 + N / 2 + 9 * N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic       o_frame_err, o_overrun, o_parity_err;
  logic       i_err_clr = 1'b0;

  swervolf_uart_rx #(
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err),
    .i_err_clr    (i_err_clr)
  );

  always #5 clk = ~clk;

  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  bit  cmp_en      = 1'b0;
  bit  rand_ready  = 1'b0;
  int  ready_on_cyc = -1;

  byte unsigned q[$];
  byte unsigned push_at[int];
  bit           ferr_at[int];
  bit           perr_at[int];
  bit           m_frame, m_over, m_par;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue fed at the cycle each frame is due to land.
  always @(posedge clk) begin
    bit fe, ov, pe;
    cyc++;
    fe = 1'b0; ov = 1'b0; pe = 1'b0;
    if (rst) begin
      q.delete(); push_at.delete(); ferr_at.delete(); perr_at.delete();
      m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0;
    end else begin
      if (q.size() != 0 && i_ready) void'(q.pop_front());
      if (push_at.exists(cyc)) begin
        if (q.size() < DEPTH) q.push_back(push_at[cyc]);
        else ov = 1'b1;
        push_at.delete(cyc);
      end
      if (ferr_at.exists(cyc)) begin fe = 1'b1; ferr_at.delete(cyc); end
      if (perr_at.exists(cyc)) begin pe = 1'b1; perr_at.delete(cyc); end
      if (i_err_clr) begin
        m_frame = 1'b0; m_over = 1'b0; m_par = 1'b0;
      end else begin
        m_frame |= fe; m_over |= ov; m_par |= pe;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", o_valid, q.size() != 0);
      if (q.size() != 0) check("data", o_data, q[0]);
      check("frame_err", o_frame_err, m_frame);
      check("overrun", o_overrun, m_over);
      check("parity_err", o_parity_err, m_par);
    end
  end

  task automatic step();
    @(negedge clk);
    if (ready_on_cyc == cyc + 1) i_ready = 1'b1;
    else if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  // Drives one frame starting at the current negedge; returns N*FRAME_BITS cycles later.
  task automatic send_frame(input byte unsigned data, input bit stop_ok, input bit par_flip);
    int t0;
    logic [FRAME_BITS-1:0] bits;
    t0 = cyc + 1;
    bits = '0;
    bits[8:1] = data;
    if (PARITY) begin
      bits[9] = (^data) ^ par_flip;
      if (par_flip) perr_at[t0 + PAR_LAT] = 1'b1;
    end
    bits[FRAME_BITS-1] = stop_ok;
    if (stop_ok) push_at[t0 + PUSH_LAT] = data;
    else         ferr_at[t0 + PUSH_LAT - 1] = 1'b1;
    for (int i = 0; i < FRAME_BITS; i++) begin
      i_rx = bits[i];
      repeat (N) step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_valid", o_valid, 1'b0);
    check("reset_data", o_data, 8'h00);
    check("reset_flags", {o_frame_err, o_overrun, o_parity_err}, 3'b000);

    // Single byte with consumer ready: visible for exactly one cycle.
    i_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("single_valid", o_valid, 1'b1);
    check("single_data", o_data, 8'hA5);
    step();
    check("single_popped", o_valid, 1'b0);
    repeat (10) step();

    // Three-cycle glitch on the line.
    i_rx = 1'b0;
    repeat (3) step();
    i_rx = 1'b1;
    repeat (20) step();
    check("glitch_valid", o_valid, 1'b0);
    check("glitch_flags", {o_frame_err, o_overrun}, 2'b00);

    // Bad stop bit, then line held low; clear mid-hold must stay clear.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_set", o_frame_err, 1'b1);
    repeat (20) step();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    check("ferr_cleared", o_frame_err, 1'b0);
    repeat (19) step();
    i_rx = 1'b1;
    repeat (10) step();
    check("ferr_once", o_frame_err, 1'b0);
    check("ferr_no_push", o_valid, 1'b0);

    // Overrun: five frames into a four-entry FIFO with no consumer.
    i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_frame(byte'(b), 1'b1, 1'b0);
    check("ovr_flag", o_overrun, 1'b1);
    check("ovr_head", o_data, 8'h01);
    i_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      check("ovr_drain", o_data, 32'(b));
      step();
    end
    check("ovr_empty", o_valid, 1'b0);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    check("ovr_cleared", o_overrun, 1'b0);

    // Full FIFO, pop on exactly the cycle of the fifth push.
    i_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_frame(byte'(8'h11 + b), 1'b1, 1'b0);
    ready_on_cyc = cyc + 1 + PUSH_LAT;
    send_frame(8'h15, 1'b1, 1'b0);
    ready_on_cyc = -1;
    check("pp_no_overrun", o_overrun, 1'b0);
    check("pp_head", o_data, 8'h12);
    repeat (8) step();
    check("pp_drained", o_valid, 1'b0);

    // Reset in the middle of a frame with a byte still buffered.
    i_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    i_rx = 1'b0;
    repeat (30) step();
    rst = 1'b1;
    i_rx = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_mid_valid", o_valid, 1'b0);
    check("rst_mid_data", o_data, 8'h00);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("rst_after_data", o_data, 8'h5A);
    i_ready = 1'b1;
    repeat (4) step();

    if (PARITY) begin
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_bad", o_parity_err, 1'b1);
      i_err_clr = 1'b1;
      step();
      i_err_clr = 1'b0;
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_good", o_parity_err, 1'b0);
    end

    // Randomized traffic: random bytes, gaps, consumer stalls, bad stops, clears.
    rand_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bit stop_ok;
      int gap;
      stop_ok = ($urandom_range(0, 9) != 0);
      send_frame(byte'($urandom), stop_ok, 1'($urandom_range(0, 1)));
      gap = stop_ok ? $urandom_range(0, 12) : $urandom_range(2, 12);
      i_rx = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        if (gap > 0) gap--;
      end
      repeat (gap) step();
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    repeat (2 * PUSH_LAT) step();
    check("final_empty", o_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
